uart_alu_interface: RTL

Receive-side consumer sitting directly downstream of the UART receiver (fed by its `o_data` / `o_rx_done_tick`). It collects three consecutive received bytes (operand A, operand B, opcode), computes an 8-bit ALU result, and hands it to the UART transmitter through a start/done handshake. It is the glue between the RX path, the ALU function, and the TX path of the UART calculator system.

---
 rtl/uart_alu_interface.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_alu_interface.sv
// UART calculator glue: gathers operand A, operand B and an opcode from the
// receiver, computes an 8-bit ALU result and hands it to the transmitter with a
// start/done handshake.
// Optional feature macro: UART_ALU_TIMEOUT_EN (inter-byte timeout on partial frames).
module uart_alu_interface #(
   parameter int unsigned NB_DATA        = 8,
   parameter int unsigned NB_OP          = 6,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done_tick,
   input  logic               i_tx_done_tick,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy,
   output logic               o_overrun,
   output logic               o_timeout
);

   localparam logic [NB_OP-1:0] OpAdd = NB_OP'(6'b100000);
   localparam logic [NB_OP-1:0] OpSub = NB_OP'(6'b100010);
   localparam logic [NB_OP-1:0] OpAnd = NB_OP'(6'b100100);
   localparam logic [NB_OP-1:0] OpOr  = NB_OP'(6'b100101);
   localparam logic [NB_OP-1:0] OpXor = NB_OP'(6'b100110);
   localparam logic [NB_OP-1:0] OpNor = NB_OP'(6'b100111);
   localparam logic [NB_OP-1:0] OpSra = NB_OP'(6'b000011);
   localparam logic [NB_OP-1:0] OpSrl = NB_OP'(6'b000010);

   typedef enum logic [2:0] {StWaitA, StWaitB, StWaitOp, StSend, StWaitTx} state_e;

   state_e             state_q, state_d;
   logic [NB_DATA-1:0] a_q, a_d;
   logic [NB_DATA-1:0] b_q, b_d;
   logic [NB_OP-1:0]   op_q, op_d;
   logic [NB_DATA-1:0] tx_data_q, tx_data_d;
   logic               tx_start_q, tx_start_d;
   logic               busy_q, busy_d;
   logic               overrun_q, overrun_d;
   logic               timeout_hit;

   // Shift amount is the whole B byte; oversize shifts saturate naturally.
   function automatic logic [NB_DATA-1:0] alu(input logic [NB_DATA-1:0] a,
                                              input logic [NB_DATA-1:0] b,
                                              input logic [NB_OP-1:0]   op);
      logic [NB_DATA-1:0] r;
      case (op)
         OpAdd:   r = a + b;
         OpSub:   r = a - b;
         OpAnd:   r = a & b;
         OpOr:    r = a | b;
         OpXor:   r = a ^ b;
         OpNor:   r = ~(a | b);
         OpSra:   r = $signed(a) >>> b;
         OpSrl:   r = a >> b;
         default: r = '0;
      endcase
      return r;
   endfunction

`ifdef UART_ALU_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            timeout_q;
   logic            waiting;

   // Idle counter: runs only while a partial frame is pending and no byte arrives.
   always_comb begin
      waiting     = (state_q == StWaitB) || (state_q == StWaitOp);
      timeout_hit = waiting && !i_rx_done_tick && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
      cnt_d       = '0;
      if (waiting && !i_rx_done_tick && !timeout_hit) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter and timeout pulse registers.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_hit;
      end
   end

   assign o_timeout = timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign o_timeout   = 1'b0;
`endif

   // Next-state and registered-output logic for the frame FSM.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      busy_d     = busy_q;
      overrun_d  = overrun_q;
      case (state_q)
         StWaitA: begin
            if (i_rx_done_tick) begin
               a_d     = i_rx_data;
               state_d = StWaitB;
            end
         end
         StWaitB: begin
            if (i_rx_done_tick) begin
               b_d     = i_rx_data;
               state_d = StWaitOp;
            end else if (timeout_hit) begin
               state_d = StWaitA;
            end
         end
         StWaitOp: begin
            if (i_rx_done_tick) begin
               // Result is registered now so data is valid alongside the start pulse.
               op_d       = i_rx_data[NB_OP-1:0];
               tx_data_d  = alu(a_q, b_q, op_d);
               tx_start_d = 1'b1;
               busy_d     = 1'b1;
               state_d    = StSend;
            end else if (timeout_hit) begin
               state_d = StWaitA;
            end
         end
         StSend: begin
            overrun_d = overrun_q | i_rx_done_tick;
            state_d   = StWaitTx;
         end
         StWaitTx: begin
            overrun_d = overrun_q | i_rx_done_tick;
            if (i_tx_done_tick) begin
               busy_d  = 1'b0;
               state_d = StWaitA;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = StWaitA;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= StWaitA;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
      end
   end

   assign o_tx_data  = tx_data_q;
   assign o_tx_start = tx_start_q;
   assign o_busy     = busy_q;
   assign o_overrun  = overrun_q;

endmodule
